// File: rtl/bcd_alu_seq_if.sv
// Handshake and data bus of the sequential BCD ALU.
// master drives requests (testbench / host side), slave is the ALU.
interface bcd_alu_seq_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic [1:0]            op;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [8*DIGITS-1:0]   result;
  logic                  neg;
  logic                  err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, neg, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, neg, err
  );
endinterface

// File: rtl/bcd_alu_seq.sv
// Sequential BCD ALU: add / subtract / multiply / divide on DIGITS-digit
// BCD operands. Operands are converted to binary one digit per cycle,
// the operation runs in binary (shift-add multiply, restoring divide),
// and the 2*BW-bit binary value goes back to BCD by double-dabble.
module bcd_alu_seq #(
  parameter int DIGITS = 2
) (
  input logic           clk,
  input logic           rst,
  bcd_alu_seq_if.slave  alu
);
  localparam int POW = 10 ** DIGITS;
  localparam int BW  = $clog2(POW);
  localparam int W2  = 2 * BW;
  localparam int ND  = 2 * DIGITS;
  localparam int DW  = 4 * DIGITS;
  localparam int RW  = 8 * DIGITS;
  localparam int CW  = $clog2(W2 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_OUT,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic [DW-1:0]   a_bcd_q, b_bcd_q;   // digit shifters, MSD consumed first
  logic [W2-1:0]   opa_q;              // A binary; multiplicand / dividend+quotient
  logic [BW-1:0]   b_q;                // B binary; multiplier / divisor
  logic [BW-1:0]   rem_q;              // restoring-divide partial remainder
  logic [W2-1:0]   acc_q;              // binary result fed to double-dabble
  logic [RW-1:0]   bcd_q;              // double-dabble BCD accumulator
  logic            sneg_q;             // subtract sign, published at DONE
  logic            busy_q, done_q, neg_q, err_q;
  logic [RW-1:0]   result_q;

  // Request-time error detection: any non-BCD digit, or divide by zero.
  function automatic logic bcd_bad(input logic [DW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  logic            err_in;
  logic [3:0]      a_dig, b_dig;
  logic [W2-1:0]   opa_ld;
  logic [BW-1:0]   b_ld;
  logic [BW:0]     div_sh, rem_n;
  logic            div_ge;
  logic [BW-1:0]   quo_n;
  logic [W2-1:0]   div_pack;
  logic [RW-1:0]   dd_adj, dd_next;

  // Datapath helpers: digit load, one restoring-divide step, one dabble step.
  always_comb begin
    err_in = bcd_bad(alu.a) || bcd_bad(alu.b) ||
             ((alu.op == 2'b11) && (alu.b == '0));

    a_dig  = a_bcd_q[DW-1 -: 4];
    b_dig  = b_bcd_q[DW-1 -: 4];
    opa_ld = (opa_q * W2'(10)) + W2'(a_dig);
    b_ld   = (b_q * BW'(10)) + BW'(b_dig);

    div_sh = {rem_q, opa_q[BW-1]};
    div_ge = (div_sh >= {1'b0, b_q});
    rem_n  = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
    quo_n  = {opa_q[BW-2:0], div_ge};
    // Remainder lands in the upper DIGITS decimal digits, quotient in the lower.
    div_pack = (W2'(rem_n) * W2'(POW)) + W2'(quo_n);

    dd_adj = bcd_q;
    for (int i = 0; i < ND; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    dd_next = (dd_adj << 1) | {{(RW-1){1'b0}}, acc_q[W2-1]};
  end

  // Control FSM and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_bcd_q  <= '0;
      b_bcd_q  <= '0;
      opa_q    <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      bcd_q    <= '0;
      sneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (alu.start) begin
            op_q     <= alu.op;
            a_bcd_q  <= alu.a;
            b_bcd_q  <= alu.b;
            opa_q    <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            sneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            if (err_in) begin
              // Bad request short-circuits straight to the done pulse.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          opa_q   <= opa_ld;
          b_q     <= b_ld;
          a_bcd_q <= a_bcd_q << 4;
          b_bcd_q <= b_bcd_q << 4;
          if (cnt_q == CW'(DIGITS - 1)) begin
            cnt_q   <= '0;
            state_q <= S_EXEC;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_EXEC: begin
          bcd_q <= '0;
          case (op_q)
            2'b00: acc_q <= opa_q + W2'(b_q);
            2'b01: begin
              if (opa_q < W2'(b_q)) begin
                acc_q  <= W2'(b_q) - opa_q;
                sneg_q <= 1'b1;
              end else begin
                acc_q  <= opa_q - W2'(b_q);
              end
            end
            2'b10: begin
              if (b_q[0]) acc_q <= acc_q + opa_q;
              opa_q <= opa_q << 1;
              b_q   <= b_q >> 1;
            end
            default: begin
              rem_q         <= rem_n[BW-1:0];
              opa_q[BW-1:0] <= quo_n;
              acc_q         <= div_pack;
            end
          endcase
          if (!op_q[1] || (cnt_q == CW'(BW - 1))) begin
            cnt_q   <= '0;
            state_q <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_OUT: begin
          bcd_q <= dd_next;
          acc_q <= acc_q << 1;
          if (cnt_q == CW'(W2 - 1)) begin
            cnt_q    <= '0;
            result_q <= dd_next;
            neg_q    <= sneg_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu.busy   = busy_q;
  assign alu.done   = done_q;
  assign alu.result = result_q;
  assign alu.neg    = neg_q;
  assign alu.err    = err_q;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq (DIGITS=2): directed vectors push their
// expected response at accept; a forked monitor pops on every done pulse.
module tb_bcd_alu_seq;
  localparam int DIGITS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_alu_seq_if #(.DIGITS(DIGITS)) alu ();
  bcd_alu_seq #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .alu(alu));

  typedef struct {
    logic [15:0] res;
    logic        neg;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Latency counts the accept edge itself, so an error response is 1.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (alu.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'b0, alu.done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", {16'b0, alu.result}, {16'b0, e.res});
          chk("neg", {31'b0, alu.neg}, {31'b0, e.neg});
          chk("err", {31'b0, alu.err}, {31'b0, e.err});
          chk("latency", cyc - e.acc_cyc + 1, e.lat);
          chk("busy_at_done", {31'b0, alu.busy}, 32'd0);
        end
      end
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [15:0] res, input logic neg, input logic err,
                       input int lat);
    exp_t e;
    @(negedge clk);
    alu.a = a; alu.b = b; alu.op = op; alu.start = 1'b1;
    @(posedge clk);
    #1;
    alu.start = 1'b0;
    // Captured operands must not track later input changes.
    alu.a = 8'h77; alu.b = 8'h00; alu.op = 2'b11;
    e.res = res; e.neg = neg; e.err = err; e.lat = lat; e.acc_cyc = cyc;
    sb.push_back(e);
    chk("clear_on_accept", {16'b0, alu.result}, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                     input logic [15:0] res, input logic neg, input logic err,
                     input int lat);
    issue(a, b, op, res, neg, err, lat);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_result", {16'b0, alu.result}, {16'b0, res});
    chk("idle_busy", {31'b0, alu.busy}, 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1;
    alu.start = 1'b0; alu.op = 2'b00; alu.a = '0; alu.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, alu.busy}, 32'd0);
    chk("rst_done", {31'b0, alu.done}, 32'd0);
    chk("rst_result", {16'b0, alu.result}, 32'd0);
    chk("rst_neg", {31'b0, alu.neg}, 32'd0);
    chk("rst_err", {31'b0, alu.err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(8'h45, 8'h67, 2'b00, 16'h0112, 1'b0, 1'b0, 18);
    run(8'h06, 8'h09, 2'b01, 16'h0003, 1'b1, 1'b0, 18);
    run(8'h50, 8'h50, 2'b01, 16'h0000, 1'b0, 1'b0, 18);
    run(8'h00, 8'h99, 2'b01, 16'h0099, 1'b1, 1'b0, 18);
    run(8'h99, 8'h99, 2'b00, 16'h0198, 1'b0, 1'b0, 18);

    // Multiply with a start pulse while busy: exactly one done expected.
    issue(8'h99, 8'h99, 2'b10, 16'h9801, 1'b0, 1'b0, 24);
    chk("busy_in_load", {31'b0, alu.busy}, 32'd1);
    repeat (5) @(negedge clk);
    alu.a = 8'h11; alu.b = 8'h22; alu.op = 2'b00; alu.start = 1'b1;
    repeat (2) @(negedge clk);
    alu.start = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);

    run(8'h12, 8'h00, 2'b10, 16'h0000, 1'b0, 1'b0, 24);
    run(8'h85, 8'h06, 2'b11, 16'h0114, 1'b0, 1'b0, 24);
    run(8'h07, 8'h09, 2'b11, 16'h0700, 1'b0, 1'b0, 24);
    run(8'h99, 8'h01, 2'b11, 16'h0099, 1'b0, 1'b0, 24);
    run(8'h85, 8'h00, 2'b11, 16'h0000, 1'b0, 1'b1, 1);
    run(8'h00, 8'h00, 2'b11, 16'h0000, 1'b0, 1'b1, 1);
    run(8'h1A, 8'h05, 2'b00, 16'h0000, 1'b0, 1'b1, 1);
    run(8'h23, 8'h9F, 2'b10, 16'h0000, 1'b0, 1'b1, 1);

    // Reset 10 cycles into a multiply aborts it with no done.
    issue(8'h12, 8'h34, 2'b10, 16'h0408, 1'b0, 1'b0, 24);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("abort_busy", {31'b0, alu.busy}, 32'd0);
    chk("abort_done", {31'b0, alu.done}, 32'd0);
    chk("abort_result", {16'b0, alu.result}, 32'd0);
    chk("abort_err", {31'b0, alu.err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run(8'h33, 8'h44, 2'b00, 16'h0077, 1'b0, 1'b0, 18);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1;
    alu.a = 8'h11; alu.b = 8'h11; alu.op = 2'b00; alu.start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_prio_busy", {31'b0, alu.busy}, 32'd0);
    chk("rst_prio_result", {16'b0, alu.result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    alu.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_prio_idle", {31'b0, alu.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_alu_seq.md
BCD_ALU_SEQ -- requirements
Module: bcd_alu_seq

Interface
REQ-001 Parameter DIGITS, default 2, gives BCD digits per operand; legal range 1..4.
REQ-002 Localparam BW, value ceil(log2(10^DIGITS)) (7 for DIGITS=2), gives the internal binary width per operand.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 op  input  2  00 add, 01 subtract, 10 multiply, 11 divide.
REQ-007 a  input  4*DIGITS  BCD operand A, digit 0 at LSBs.
REQ-008 b  input  4*DIGITS  BCD operand B, digit 0 at LSBs.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when result, neg and err are valid.
REQ-011 result  output  8*DIGITS  BCD result, 2*DIGITS digits.
REQ-012 neg  output  1  subtract result is negative.
REQ-013 err  output  1  invalid BCD digit on a or b, or divide by zero.

Function
REQ-014 States SHALL be IDLE, LOAD, EXEC, OUT and DONE.
REQ-015 Accept: start=1 in IDLE captures a, b and op on that edge and moves to LOAD; input changes after accept SHALL be ignored.
REQ-016 start SHALL be ignored in LOAD, EXEC, OUT and DONE, with no queuing.
REQ-017 LOAD SHALL convert both operands from BCD to binary in exactly DIGITS cycles.
REQ-018 EXEC SHALL take 1 cycle for add and subtract, and BW cycles for multiply (shift-add) and divide (restoring).
REQ-019 OUT SHALL convert the 2*BW-bit binary value to BCD by double-dabble in exactly 2*BW cycles.
REQ-020 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-021 Latency from accept edge to the done-high cycle SHALL be DIGITS+E+2*BW+1 cycles, where E is the EXEC length (DIGITS=2: add/sub 18, mul/div 24).
REQ-022 busy SHALL be 1 in LOAD, EXEC and OUT, and 0 in IDLE and DONE.
REQ-023 Add: result = a+b, with the carry digit in digit DIGITS and upper digits 0.
REQ-024 Subtract: result = |a-b|; neg=1 iff a<b; a=b gives result 0 and neg=0.
REQ-025 Multiply: result = a*b across all 2*DIGITS digits.
REQ-026 Divide: quotient in result[4*DIGITS-1:0], remainder in result[8*DIGITS-1:4*DIGITS].
REQ-027 neg SHALL be 0 for every op other than subtract.
REQ-028 Any captured digit >9 in a or b, or op=11 with b=0, SHALL set err=1 and result=0, go directly from the accept edge to DONE, and pulse done in the cycle after accept.
REQ-029 result, neg and err SHALL hold their values from DONE until the next accept edge, and clear to 0 on that edge.
REQ-030 A 0/0 divide SHALL report err=1, not a quotient.

Reset
REQ-031 rst=1 SHALL force IDLE on the next edge, with busy=0, done=0, result=0, neg=0 and err=0.
REQ-032 rst SHALL take priority over start in the same cycle; the start is not accepted.
REQ-033 rst asserted mid-operation SHALL abort the operation with no done pulse; the next start after rst deasserts is accepted normally.

Verification (DIGITS=2)
REQ-034 a=0x45, b=0x67, op=00 -> done 18 cycles after accept, result=0x0112, neg=0, err=0.
REQ-035 a=0x06, b=0x09, op=01 -> result=0x0003, neg=1; then a=b=0x50 -> result=0x0000, neg=0.
REQ-036 a=0x99, b=0x99, op=10 -> done at 24 cycles, result=0x9801; start pulsed during busy is ignored, with exactly one done.
REQ-037 a=0x85, b=0x06, op=11 -> result=0x0114 (quotient 14, remainder 01); b=0x00 -> err=1, result=0, done 1 cycle after accept.
REQ-038 a=0x1A, op=00 -> err=1, result=0, done 1 cycle after accept.
REQ-039 rst pulsed 10 cycles into a multiply -> busy=0 and outputs 0 on the next edge, no done; a following add then completes in 18 cycles.
